axi2ddr_rd_guard: RTL and testbench

Parametrised AXI4 read-channel guard between the PCIe-side AXI master and the DDR3 controller AXI slave port. It forwards only legal read bursts, where legal means a permitted length, an INCR burst type and an address inside a configurable window. Every illegal burst is completed locally with the correct beat count, a poison data pattern, a SLVERR response and the original ID, so the upstream master never hangs. Per-cause error counters and a last-bad-address capture provide debug visibility.

---
 rtl/axi2ddr_rd_guard.sv | 207 ++++++++++++++++++++
 tb/tb_axi2ddr_rd_guard.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2ddr_rd_guard.sv
// AXI4 read-channel guard: forwards legal INCR bursts inside the address window to DDR.
// Every other burst is completed locally with poison data and an error response, and is counted.
module axi2ddr_rd_guard #(
  parameter int                     AXI_DATA_WD = 128,
  parameter int                     AXI_ADDR_WD = 64,
  parameter int                     AXI_ID_WD   = 4,
  parameter int                     AXI_USER_WD = 1,
  parameter logic [8:0]             LEN_MASK    = 9'h1FC,
  parameter logic [AXI_ADDR_WD-1:0] ADDR_BASE   = '0,
  parameter logic [AXI_ADDR_WD-1:0] ADDR_SIZE   = AXI_ADDR_WD'(64'h4000_0000),
  parameter logic [15:0]            ERR_WORD    = 16'hDEAD,
  parameter logic [1:0]             ERR_RESP    = 2'b10,
  parameter int                     DGBCNT_WD   = 32
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic                   cfg_rst,
  input  logic [AXI_ADDR_WD-1:0] s_axi_araddr,
  input  logic [1:0]             s_axi_arburst,
  input  logic [3:0]             s_axi_arcache,
  input  logic [AXI_ID_WD-1:0]   s_axi_arid,
  input  logic [7:0]             s_axi_arlen,
  input  logic                   s_axi_arlock,
  input  logic [2:0]             s_axi_arprot,
  input  logic [3:0]             s_axi_arqos,
  input  logic [2:0]             s_axi_arsize,
  input  logic [AXI_USER_WD-1:0] s_axi_aruser,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [AXI_DATA_WD-1:0] s_axi_rdata,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic                   s_axi_rlast,
  output logic [1:0]             s_axi_rresp,
  output logic [AXI_ID_WD-1:0]   s_axi_rid,
  output logic [AXI_ADDR_WD-1:0] m_axi_araddr,
  output logic [1:0]             m_axi_arburst,
  output logic [3:0]             m_axi_arcache,
  output logic [AXI_ID_WD-1:0]   m_axi_arid,
  output logic [7:0]             m_axi_arlen,
  output logic                   m_axi_arlock,
  output logic [2:0]             m_axi_arprot,
  output logic [3:0]             m_axi_arqos,
  output logic [2:0]             m_axi_arsize,
  output logic [AXI_USER_WD-1:0] m_axi_aruser,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [AXI_DATA_WD-1:0] m_axi_rdata,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic                   m_axi_rlast,
  input  logic [1:0]             m_axi_rresp,
  input  logic [AXI_ID_WD-1:0]   m_axi_rid,
  output logic [DGBCNT_WD-1:0]   err_len_cnt,
  output logic [DGBCNT_WD-1:0]   err_addr_cnt,
  output logic [DGBCNT_WD-1:0]   ok_rd_cnt,
  output logic [AXI_ADDR_WD-1:0] err_last_addr
);

  // state | meaning
  // IDLE  | waiting for an AR; legal ones are forwarded to DDR, illegal ones accepted locally
  // PASS  | one forwarded burst outstanding; R channel is a wire from DDR
  // ERR   | generating poison beats for a rejected burst
  typedef enum logic [1:0] {IDLE, PASS, ERR} state_t;

  localparam int EW = AXI_ADDR_WD + 9;

  state_t                 state;
  logic [7:0]             beat_cnt;
  logic [7:0]             len_q;
  logic [AXI_ID_WD-1:0]   id_q;

  logic                   len_ok;
  logic                   addr_ok;
  logic                   burst_ok;
  logic                   legal;
  logic [EW-1:0]          addr_off;
  logic [EW-1:0]          end_off;

  always_comb begin
    len_ok = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (LEN_MASK[k] && ({1'b0, s_axi_arlen} == 9'((1 << k) - 1))) len_ok = 1'b1;
    end
  end

  // Window check done as an offset from the base: a negative offset sets the top bit,
  // and the burst fits when offset plus burst bytes does not pass the window size.
  always_comb begin
    addr_off = EW'(s_axi_araddr) - EW'(ADDR_BASE);
    end_off  = addr_off + ((EW'(s_axi_arlen) + EW'(1)) << s_axi_arsize);
    addr_ok  = !addr_off[EW-1] && (end_off <= EW'(ADDR_SIZE));
    burst_ok = (s_axi_arburst == 2'b01);
    legal    = len_ok && addr_ok && burst_ok;
  end

  always_comb begin
    m_axi_araddr  = '0;
    m_axi_arburst = '0;
    m_axi_arcache = '0;
    m_axi_arid    = '0;
    m_axi_arlen   = '0;
    m_axi_arlock  = 1'b0;
    m_axi_arprot  = '0;
    m_axi_arqos   = '0;
    m_axi_arsize  = '0;
    m_axi_aruser  = '0;
    m_axi_arvalid = 1'b0;
    s_axi_arready = 1'b0;
    if (state == IDLE && s_axi_arvalid) begin
      if (legal) begin
        m_axi_araddr  = s_axi_araddr;
        m_axi_arburst = s_axi_arburst;
        m_axi_arcache = s_axi_arcache;
        m_axi_arid    = s_axi_arid;
        m_axi_arlen   = s_axi_arlen;
        m_axi_arlock  = s_axi_arlock;
        m_axi_arprot  = s_axi_arprot;
        m_axi_arqos   = s_axi_arqos;
        m_axi_arsize  = s_axi_arsize;
        m_axi_aruser  = s_axi_aruser;
        m_axi_arvalid = 1'b1;
        s_axi_arready = m_axi_arready;
      end else begin
        s_axi_arready = 1'b1;
      end
    end
  end

  always_comb begin
    s_axi_rdata  = {(AXI_DATA_WD/16){ERR_WORD}};
    s_axi_rresp  = ERR_RESP;
    s_axi_rid    = id_q;
    s_axi_rlast  = (beat_cnt == len_q);
    s_axi_rvalid = (state == ERR);
    m_axi_rready = 1'b0;
    if (state == PASS) begin
      s_axi_rdata  = m_axi_rdata;
      s_axi_rresp  = m_axi_rresp;
      s_axi_rid    = m_axi_rid;
      s_axi_rlast  = m_axi_rlast;
      s_axi_rvalid = m_axi_rvalid;
      m_axi_rready = s_axi_rready;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      len_q         <= '0;
      id_q          <= '0;
      err_len_cnt   <= '0;
      err_addr_cnt  <= '0;
      ok_rd_cnt     <= '0;
      err_last_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_arvalid) begin
            if (legal) begin
              if (m_axi_arready) begin
                state <= PASS;
                if (ok_rd_cnt != '1) ok_rd_cnt <= ok_rd_cnt + 1'b1;
              end
            end else begin
              state         <= ERR;
              id_q          <= s_axi_arid;
              len_q         <= s_axi_arlen;
              err_last_addr <= s_axi_araddr;
              if (!len_ok) begin
                if (err_len_cnt != '1) err_len_cnt <= err_len_cnt + 1'b1;
              end else begin
                if (err_addr_cnt != '1) err_addr_cnt <= err_addr_cnt + 1'b1;
              end
            end
          end
        end
        PASS: begin
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) state <= IDLE;
        end
        ERR: begin
          if (cfg_rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (s_axi_rready) begin
            if (beat_cnt == len_q) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a debug clear overrides any same-cycle increment or capture.
      if (cfg_rst) begin
        err_len_cnt   <= '0;
        err_addr_cnt  <= '0;
        ok_rd_cnt     <= '0;
        err_last_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi2ddr_rd_guard.sv
// Directed bench for axi2ddr_rd_guard: forwarding, local error bursts, backpressure,
// debug clear, back-to-back acceptance, async reset and counter saturation (4-bit counters).
module tb_axi2ddr_rd_guard;

  localparam logic [127:0] ERR_DATA = {8{16'hDEAD}};

  logic         axi_clk = 1'b0;
  logic         axi_rst;
  logic         cfg_rst;
  logic [63:0]  s_axi_araddr;
  logic [1:0]   s_axi_arburst;
  logic [3:0]   s_axi_arcache;
  logic [3:0]   s_axi_arid;
  logic [7:0]   s_axi_arlen;
  logic         s_axi_arlock;
  logic [2:0]   s_axi_arprot;
  logic [3:0]   s_axi_arqos;
  logic [2:0]   s_axi_arsize;
  logic [0:0]   s_axi_aruser;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [127:0] s_axi_rdata;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic         s_axi_rlast;
  logic [1:0]   s_axi_rresp;
  logic [3:0]   s_axi_rid;
  logic [63:0]  m_axi_araddr;
  logic [1:0]   m_axi_arburst;
  logic [3:0]   m_axi_arcache;
  logic [3:0]   m_axi_arid;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_arlock;
  logic [2:0]   m_axi_arprot;
  logic [3:0]   m_axi_arqos;
  logic [2:0]   m_axi_arsize;
  logic [0:0]   m_axi_aruser;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic         m_axi_rlast;
  logic [1:0]   m_axi_rresp;
  logic [3:0]   m_axi_rid;
  logic [3:0]   err_len_cnt;
  logic [3:0]   err_addr_cnt;
  logic [3:0]   ok_rd_cnt;
  logic [63:0]  err_last_addr;

  int checks = 0;
  int errors = 0;

  axi2ddr_rd_guard #(.DGBCNT_WD(4)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .cfg_rst(cfg_rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arlock(s_axi_arlock),
    .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arsize(s_axi_arsize),
    .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arlock(m_axi_arlock),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arsize(m_axi_arsize),
    .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid),
    .err_len_cnt(err_len_cnt), .err_addr_cnt(err_addr_cnt), .ok_rd_cnt(ok_rd_cnt),
    .err_last_addr(err_last_addr)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: all are entered and left at posedge + 1.
  task automatic clear_dbg();
    cfg_rst = 1'b1;
    @(posedge axi_clk); #1;
    cfg_rst = 1'b0;
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1;
    @(posedge axi_clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic test_reset();
    axi_rst = 1'b1;
    #1;
    checks++;
    if (s_axi_arready !== 1'b0 || m_axi_arvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got arready=%b m_arvalid=%b rvalid=%b m_rready=%b exp all 0",
               s_axi_arready, m_axi_arvalid, s_axi_rvalid, m_axi_rready);
    end
    checks++;
    if (err_len_cnt !== 4'd0 || err_addr_cnt !== 4'd0 || ok_rd_cnt !== 4'd0 || err_last_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_debug got len=%0d addr=%0d ok=%0d last=%h exp 0", err_len_cnt, err_addr_cnt, ok_rd_cnt, err_last_addr);
    end
    @(posedge axi_clk); #1;
    axi_rst = 1'b0;
    @(posedge axi_clk); #1;
    checks++;
    if (s_axi_arready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_arvalid_arready got %b exp 0", s_axi_arready);
    end
  endtask

  task automatic test_legal();
    int beats = 0;
    logic [127:0] exp_data;
    clear_dbg();
    m_axi_arready = 1'b0;
    s_axi_araddr = 64'h1000; s_axi_arlen = 8'd15; s_axi_arsize = 3'd4;
    s_axi_arburst = 2'b01; s_axi_arid = 4'd2; s_axi_arvalid = 1'b1;
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h1000 || m_axi_arlen !== 8'd15 ||
        m_axi_arid !== 4'd2 || m_axi_arburst !== 2'b01 || m_axi_arsize !== 3'd4) begin
      errors++;
      $display("FAIL legal_fwd got v=%b a=%h l=%0d id=%0d exp 1 1000 15 2", m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid);
    end
    checks++;
    if (s_axi_arready !== 1'b0) begin
      errors++;
      $display("FAIL legal_arready_follow got %b exp 0", s_axi_arready);
    end
    m_axi_arready = 1'b1;
    #1;
    checks++;
    if (s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL legal_arready_hs got %b exp 1", s_axi_arready);
    end
    @(posedge axi_clk); #1;
    s_axi_arvalid = 1'b0;
    m_axi_arready = 1'b0;
    s_axi_rready = 1'b1;
    checks++;
    if (ok_rd_cnt !== 4'd1 || m_axi_arvalid !== 1'b0 || m_axi_araddr !== 64'd0) begin
      errors++;
      $display("FAIL legal_after_ar got ok=%0d m_arvalid=%b m_araddr=%h exp 1 0 0", ok_rd_cnt, m_axi_arvalid, m_axi_araddr);
    end
    for (int i = 0; i < 16; i++) begin
      exp_data = {4{32'hC0DE_0000 + 32'(i)}};
      m_axi_rvalid = 1'b1; m_axi_rdata = exp_data; m_axi_rlast = (i == 15);
      m_axi_rid = 4'd2; m_axi_rresp = 2'b00;
      #1;
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rlast !== (i == 15) ||
          s_axi_rid !== 4'd2 || s_axi_rresp !== 2'b00 || m_axi_rready !== 1'b1) begin
        errors++;
        $display("FAIL legal_beat%0d got v=%b d=%h last=%b id=%0d mrr=%b", i, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid, m_axi_rready);
      end
      if (s_axi_rvalid && s_axi_rready) beats++;
      @(posedge axi_clk); #1;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1;
    checks++;
    if (beats != 16 || m_axi_rready !== 1'b0) begin
      errors++;
      $display("FAIL legal_done got beats=%0d m_rready=%b exp 16 0", beats, m_axi_rready);
    end
  endtask

  task automatic test_illegal_len();
    clear_dbg();
    s_axi_araddr = 64'h2000; s_axi_arlen = 8'd5; s_axi_arsize = 3'd4;
    s_axi_arburst = 2'b01; s_axi_arid = 4'd3; s_axi_arvalid = 1'b1;
    #1;
    checks++;
    if (s_axi_arready !== 1'b1 || m_axi_arvalid !== 1'b0 || m_axi_araddr !== 64'd0) begin
      errors++;
      $display("FAIL len_accept got arready=%b m_arvalid=%b m_araddr=%h exp 1 0 0", s_axi_arready, m_axi_arvalid, m_axi_araddr);
    end
    @(posedge axi_clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== ERR_DATA || s_axi_rresp !== 2'b10 ||
          s_axi_rid !== 4'd3 || s_axi_rlast !== (i == 5) || m_axi_rready !== 1'b0) begin
        errors++;
        $display("FAIL len_beat%0d got v=%b d=%h resp=%b id=%0d last=%b", i, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast);
      end
      @(posedge axi_clk); #1;
    end
    checks++;
    if (s_axi_rvalid !== 1'b0 || err_len_cnt !== 4'd1 || err_addr_cnt !== 4'd0 || err_last_addr !== 64'h2000) begin
      errors++;
      $display("FAIL len_done got rvalid=%b len=%0d addr=%0d last=%h exp 0 1 0 2000", s_axi_rvalid, err_len_cnt, err_addr_cnt, err_last_addr);
    end
  endtask

  task automatic test_window();
    clear_dbg();
    m_axi_arready = 1'b0;
    // Last beat lands exactly on the final window byte: still legal.
    s_axi_araddr = 64'h3FFF_FF00; s_axi_arlen = 8'd15; s_axi_arsize = 3'd4;
    s_axi_arburst = 2'b01; s_axi_arid = 4'd1; s_axi_arvalid = 1'b1;
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL win_edge_legal got m_arvalid=%b exp 1", m_axi_arvalid);
    end
    s_axi_araddr = 64'h3FFF_FF10;
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL win_over_reject got m_arvalid=%b arready=%b exp 0 1", m_axi_arvalid, s_axi_arready);
    end
    @(posedge axi_clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rlast !== (i == 15)) begin
        errors++;
        $display("FAIL win_beat%0d got v=%b last=%b", i, s_axi_rvalid, s_axi_rlast);
      end
      @(posedge axi_clk); #1;
    end
    checks++;
    if (s_axi_rvalid !== 1'b0 || err_addr_cnt !== 4'd1 || err_len_cnt !== 4'd0 || err_last_addr !== 64'h3FFF_FF10) begin
      errors++;
      $display("FAIL win_done got rvalid=%b addr=%0d len=%0d last=%h exp 0 1 0 3fffff10", s_axi_rvalid, err_addr_cnt, err_len_cnt, err_last_addr);
    end
    send_ar(64'h100, 8'd3, 3'd4, 2'b00, 4'd1);
    repeat (4) begin @(posedge axi_clk); #1; end
    checks++;
    if (err_addr_cnt !== 4'd2 || err_len_cnt !== 4'd0 || s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_burst got addr=%0d len=%0d rvalid=%b exp 2 0 0", err_addr_cnt, err_len_cnt, s_axi_rvalid);
    end
  endtask

  task automatic test_backpressure();
    int b = 0;
    int hs = 0;
    clear_dbg();
    s_axi_rready = 1'b0;
    send_ar(64'h40, 8'd3, 3'd4, 2'b00, 4'd9);
    for (int c = 0; c < 20; c++) begin
      if (b == 4) break;
      s_axi_rready = (c % 3 == 0);
      #1;
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rid !== 4'd9 || s_axi_rdata !== ERR_DATA || s_axi_rlast !== (b == 3)) begin
        errors++;
        $display("FAIL bp_cycle%0d got v=%b id=%0d last=%b exp 1 9 %b", c, s_axi_rvalid, s_axi_rid, s_axi_rlast, (b == 3));
      end
      if (s_axi_rvalid && s_axi_rready) hs++;
      if (s_axi_rready) b++;
      @(posedge axi_clk); #1;
    end
    checks++;
    if (hs != 4 || s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got handshakes=%0d rvalid=%b exp 4 0", hs, s_axi_rvalid);
    end
    s_axi_rready = 1'b1;
  endtask

  task automatic test_cfg_rst();
    logic [127:0] exp_data;
    clear_dbg();
    s_axi_rready = 1'b1;
    send_ar(64'h80, 8'd7, 3'd4, 2'b00, 4'd4);
    checks++;
    if (err_addr_cnt !== 4'd1 || err_last_addr !== 64'h80) begin
      errors++;
      $display("FAIL cfg_pre got addr=%0d last=%h exp 1 80", err_addr_cnt, err_last_addr);
    end
    repeat (2) begin @(posedge axi_clk); #1; end
    cfg_rst = 1'b1;
    #1;
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rlast !== 1'b0) begin
      errors++;
      $display("FAIL cfg_beat2 got v=%b last=%b exp 1 0", s_axi_rvalid, s_axi_rlast);
    end
    @(posedge axi_clk); #1;
    cfg_rst = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b0 || err_addr_cnt !== 4'd0 || err_len_cnt !== 4'd0 || err_last_addr !== 64'd0) begin
      errors++;
      $display("FAIL cfg_abort got rvalid=%b addr=%0d len=%0d last=%h exp 0 0 0 0", s_axi_rvalid, err_addr_cnt, err_len_cnt, err_last_addr);
    end
    m_axi_arready = 1'b1;
    send_ar(64'h3000, 8'd3, 3'd4, 2'b01, 4'd7);
    m_axi_arready = 1'b0;
    checks++;
    if (ok_rd_cnt !== 4'd1) begin
      errors++;
      $display("FAIL cfg_pass_ok got %0d exp 1", ok_rd_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      exp_data = {2{64'hFACE_0000_0000_0000 + 64'(i)}};
      m_axi_rvalid = 1'b1; m_axi_rdata = exp_data; m_axi_rlast = (i == 3); m_axi_rid = 4'd7;
      cfg_rst = (i == 1);
      #1;
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rlast !== (i == 3) || m_axi_rready !== 1'b1) begin
        errors++;
        $display("FAIL cfg_pass_beat%0d got v=%b d=%h last=%b mrr=%b", i, s_axi_rvalid, s_axi_rdata, s_axi_rlast, m_axi_rready);
      end
      @(posedge axi_clk); #1;
    end
    cfg_rst = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1;
    checks++;
    if (m_axi_rready !== 1'b0 || ok_rd_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cfg_pass_done got m_rready=%b ok=%0d exp 0 0", m_axi_rready, ok_rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_dbg();
    s_axi_rready = 1'b1;
    send_ar(64'h500, 8'd0, 3'd4, 2'b01, 4'd5);
    s_axi_araddr = 64'h600; s_axi_arlen = 8'd1; s_axi_arid = 4'd6; s_axi_arvalid = 1'b1;
    #1;
    checks++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rlast !== 1'b1 || s_axi_rid !== 4'd5 || s_axi_arready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_len0 got v=%b last=%b id=%0d arready=%b exp 1 1 5 0", s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_arready);
    end
    @(posedge axi_clk); #1;
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got rvalid=%b arready=%b exp 0 1", s_axi_rvalid, s_axi_arready);
    end
    @(posedge axi_clk); #1;
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rid !== 4'd6 || s_axi_rlast !== (i == 1)) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b id=%0d last=%b", i, s_axi_rvalid, s_axi_rid, s_axi_rlast);
      end
      @(posedge axi_clk); #1;
    end
    checks++;
    if (s_axi_rvalid !== 1'b0 || err_len_cnt !== 4'd2 || err_last_addr !== 64'h600) begin
      errors++;
      $display("FAIL b2b_done got rvalid=%b len=%0d last=%h exp 0 2 600", s_axi_rvalid, err_len_cnt, err_last_addr);
    end
  endtask

  task automatic test_async_reset();
    s_axi_rready = 1'b0;
    send_ar(64'h700, 8'd5, 3'd4, 2'b01, 4'd7);
    #2;
    axi_rst = 1'b1;
    #1;
    checks++;
    if (s_axi_rvalid !== 1'b0 || err_len_cnt !== 4'd0 || err_last_addr !== 64'd0 || s_axi_rid !== 4'd0) begin
      errors++;
      $display("FAIL async_rst got rvalid=%b len=%0d last=%h rid=%0d exp 0 0 0 0", s_axi_rvalid, err_len_cnt, err_last_addr, s_axi_rid);
    end
    @(posedge axi_clk); #1;
    axi_rst = 1'b0;
    s_axi_rready = 1'b1;
  endtask

  task automatic test_saturation();
    clear_dbg();
    s_axi_rready = 1'b1;
    repeat (20) begin
      send_ar(64'h800, 8'd0, 3'd4, 2'b01, 4'd1);
      @(posedge axi_clk); #1;
    end
    checks++;
    if (err_len_cnt !== 4'hF || err_addr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL saturation got len=%0d addr=%0d exp 15 0", err_len_cnt, err_addr_cnt);
    end
  endtask

  initial begin
    axi_rst = 1'b1; cfg_rst = 1'b0;
    s_axi_araddr = '0; s_axi_arburst = 2'b01; s_axi_arcache = '0; s_axi_arid = '0;
    s_axi_arlen = '0; s_axi_arlock = 1'b0; s_axi_arprot = '0; s_axi_arqos = '0;
    s_axi_arsize = 3'd4; s_axi_aruser = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = '0; m_axi_rid = '0;
    test_reset();
    test_legal();
    test_illegal_len();
    test_window();
    test_backpressure();
    test_cfg_rst();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
